// File: rtl/ether_pkg.sv
// Shared scheduler definitions: FSM state encoding, frame-size defaults and counter widths.
package ether_pkg;

  localparam int DEF_MIN_DIBITS = 184;
  localparam int DEF_MAX_DIBITS = 6000;
  localparam int DEF_HOLDOFF    = 48;

  localparam int CNT_W  = 13;
  localparam int HOLD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_REQ,
    ST_STREAM,
    ST_PAD,
    ST_END,
    ST_HOLDOFF
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the source holding priority wins a tie, single requesters always win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_id,
  output logic       grant
);

  logic prio_q;

  // Priority passes to the source that was not just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else if (update) begin
      prio_q <= ~upd_id;
    end
  end

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = prio_q;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/ether_tx_sched.sv
// Ethernet TX scheduler: grants one of two dibit sources per frame, pads/truncates payload, enforces inter-frame holdoff.
module ether_tx_sched
  import ether_pkg::*;
#(
  parameter int MIN_DIBITS = DEF_MIN_DIBITS,
  parameter int MAX_DIBITS = DEF_MAX_DIBITS,
  parameter int HOLDOFF    = DEF_HOLDOFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] src_valid,
  input  logic [3:0] src_data,
  input  logic [1:0] src_last,
  output logic [1:0] src_ready,
  output logic       preamble_signal,
  input  logic       data_request,
  output logic       tx_valid,
  output logic [1:0] tx_data,
  output logic       data_complete,
  output logic       busy,
  output logic       grant_id,
  output logic       err_underrun,
  output logic       err_truncate
);

  localparam logic [CNT_W-1:0]  MinCnt  = CNT_W'(MIN_DIBITS);
  localparam logic [CNT_W-1:0]  MaxCnt  = CNT_W'(MAX_DIBITS);
  localparam logic [HOLD_W-1:0] HoldLim = HOLD_W'(HOLDOFF);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              drain_q, drain_d;
  logic              tx_valid_q, tx_valid_d;
  logic [1:0]        tx_data_q, tx_data_d;
  logic              pre_q, pre_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              trunc_q, trunc_d;

  logic              arb_grant;
  logic              arb_update;
  logic              sel_valid;
  logic              sel_last;
  logic [1:0]        sel_data;
  logic [CNT_W-1:0]  cnt_inc;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (src_valid),
    .update (arb_update),
    .upd_id (grant_q),
    .grant  (arb_grant)
  );

  assign sel_valid = src_valid[grant_q];
  assign sel_last  = src_last[grant_q];
  assign sel_data  = grant_q ? src_data[3:2] : src_data[1:0];
  assign cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      cnt_q      <= '0;
      hold_q     <= '0;
      drain_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 2'b00;
      pre_q      <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      drain_q    <= drain_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      pre_q      <= pre_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      trunc_q    <= trunc_d;
    end
  end

  // The preamble register is loaded on the grant so that it is high while in START.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    drain_d    = drain_q;
    tx_valid_d = 1'b0;
    tx_data_d  = 2'b00;
    pre_d      = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    trunc_d    = 1'b0;
    src_ready  = 2'b00;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|src_valid) begin
          grant_d = arb_grant;
          cnt_d   = '0;
          hold_d  = '0;
          pre_d   = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        if (data_request) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        src_ready[grant_q] = 1'b1;
        if (sel_valid) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sel_data;
          cnt_d      = cnt_inc;
          if (sel_last) begin
            state_d = (cnt_inc < MinCnt) ? ST_PAD : ST_END;
          end else if (cnt_inc == MaxCnt) begin
            trunc_d = 1'b1;
            drain_d = 1'b1;
            state_d = ST_END;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      ST_PAD: begin
        tx_valid_d = 1'b1;
        cnt_d      = cnt_inc;
        if (cnt_inc == MinCnt) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        done_d  = 1'b1;
        hold_d  = '0;
        state_d = ST_HOLDOFF;
        if (drain_q) begin
          src_ready[grant_q] = 1'b1;
          if (sel_valid && sel_last) begin
            drain_d = 1'b0;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_q != HoldLim) begin
          hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
        // Truncated frames keep consuming the source until its own last dibit arrives.
        if (drain_q) begin
          src_ready[grant_q] = 1'b1;
          if (sel_valid && sel_last) begin
            drain_d = 1'b0;
          end
        end
        if ((hold_q == HoldLim) && !drain_q) begin
          arb_update = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign preamble_signal = pre_q;
  assign tx_valid        = tx_valid_q;
  assign tx_data         = tx_data_q;
  assign data_complete   = done_q;
  assign err_underrun    = underrun_q;
  assign err_truncate    = trunc_q;
  assign busy            = (state_q != ST_IDLE);
  assign grant_id        = grant_q;

endmodule
